icache_refill_ctrl: RTL and testbench

ICACHE_REFILL_CTRL -- requirements
Module: icache_refill_ctrl

---
 rtl/icache_refill_ctrl.sv | 145 ++++++++++++++
 tb/tb_icache_refill_ctrl.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/icache_refill_ctrl.sv
// Instruction-cache line refill controller: takes one miss, issues a single burst
// read, streams the beats into the data array, then commits tag/valid.
module icache_refill_ctrl #(
  parameter int ADDR_WIDTH     = 32,
  parameter int LINE_SIZE      = 64,
  parameter int WAYS           = 4,
  parameter int MEM_DATA_WIDTH = 32,
  localparam int WW    = $clog2(WAYS),
  localparam int BEATS = LINE_SIZE * 8 / MEM_DATA_WIDTH,
  localparam int BW    = $clog2(BEATS)
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      miss_valid_i,
  output logic                      miss_ready_o,
  input  logic [ADDR_WIDTH-1:0]     miss_addr_i,
  input  logic [WW-1:0]             miss_way_i,
  input  logic                      flush_i,
  output logic                      mem_req_valid_o,
  input  logic                      mem_req_ready_i,
  output logic [ADDR_WIDTH-1:0]     mem_req_addr_o,
  output logic [7:0]                mem_req_len_o,
  input  logic                      mem_rvalid_i,
  output logic                      mem_rready_o,
  input  logic [MEM_DATA_WIDTH-1:0] mem_rdata_i,
  input  logic                      mem_rlast_i,
  input  logic                      mem_rerr_i,
  output logic                      fill_we_o,
  output logic [WW-1:0]             fill_way_o,
  output logic [ADDR_WIDTH-1:0]     fill_addr_o,
  output logic [BW-1:0]             fill_word_o,
  output logic [MEM_DATA_WIDTH-1:0] fill_data_o,
  output logic                      tag_we_o,
  output logic                      tag_valid_o,
  output logic                      refill_done_o,
  output logic                      refill_err_o,
  output logic                      busy_o
);

  localparam int OFFW = $clog2(LINE_SIZE);

  // IDLE: wait for miss | REQ: issue burst | RECV: drain beats | COMMIT: tag write
  typedef enum logic [1:0] {IDLE, REQ, RECV, COMMIT} state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [WW-1:0]         way_q, way_d;
  logic [BW-1:0]         cnt_q, cnt_d;
  logic                  err_q, err_d;
  logic                  abort_q, abort_d;
  logic                  last_beat;
  logic                  beat_acc;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      addr_q  <= '0;
      way_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      abort_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      way_q   <= way_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      abort_q <= abort_d;
    end
  end

  assign last_beat = (cnt_q == BW'(BEATS - 1));
  assign beat_acc  = (state_q == RECV) && mem_rvalid_i;

  always_comb begin
    state_d         = state_q;
    addr_d          = addr_q;
    way_d           = way_q;
    cnt_d           = cnt_q;
    err_d           = err_q;
    abort_d         = abort_q;
    miss_ready_o    = 1'b0;
    mem_req_valid_o = 1'b0;
    mem_req_addr_o  = '0;
    mem_req_len_o   = '0;
    mem_rready_o    = 1'b0;
    fill_we_o       = 1'b0;
    fill_way_o      = '0;
    fill_addr_o     = '0;
    fill_word_o     = '0;
    fill_data_o     = '0;
    tag_we_o        = 1'b0;
    tag_valid_o     = 1'b0;
    refill_done_o   = 1'b0;
    refill_err_o    = 1'b0;
    busy_o          = (state_q != IDLE);

    unique case (state_q)
      IDLE: begin
        miss_ready_o = !flush_i;
        if (miss_valid_i && !flush_i) begin
          addr_d  = {miss_addr_i[ADDR_WIDTH-1:OFFW], {OFFW{1'b0}}};
          way_d   = miss_way_i;
          cnt_d   = '0;
          err_d   = 1'b0;
          abort_d = 1'b0;
          state_d = REQ;
        end
      end
      REQ: begin
        mem_req_valid_o = 1'b1;
        mem_req_addr_o  = addr_q;
        mem_req_len_o   = 8'(BEATS - 1);
        if (flush_i) abort_d = 1'b1;
        if (mem_req_ready_i) state_d = RECV;
      end
      RECV: begin
        mem_rready_o = 1'b1;
        if (flush_i) abort_d = 1'b1;
        if (beat_acc) begin
          // A flush arriving on this very beat already suppresses its write.
          fill_we_o   = !abort_q && !flush_i && !err_q && !mem_rerr_i;
          fill_word_o = cnt_q;
          fill_data_o = mem_rdata_i;
          fill_way_o  = way_q;
          fill_addr_o = addr_q;
          cnt_d       = cnt_q + BW'(1);
          if (mem_rerr_i || (mem_rlast_i != last_beat)) err_d = 1'b1;
          if (last_beat) state_d = COMMIT;
        end
      end
      COMMIT: begin
        tag_we_o      = 1'b1;
        tag_valid_o   = !(err_q || abort_q) && !flush_i;
        fill_way_o    = way_q;
        fill_addr_o   = addr_q;
        refill_done_o = !err_q;
        refill_err_o  = err_q;
        state_d       = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_icache_refill_ctrl.sv
// Self-checking bench for icache_refill_ctrl: a bench-side memory model drives bursts,
// expected data-array writes go through a scoreboard queue.
module tb_icache_refill_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        miss_valid_i;
  logic        miss_ready_o;
  logic [31:0] miss_addr_i;
  logic [1:0]  miss_way_i;
  logic        flush_i;
  logic        mem_req_valid_o;
  logic        mem_req_ready_i;
  logic [31:0] mem_req_addr_o;
  logic [7:0]  mem_req_len_o;
  logic        mem_rvalid_i;
  logic        mem_rready_o;
  logic [31:0] mem_rdata_i;
  logic        mem_rlast_i;
  logic        mem_rerr_i;
  logic        fill_we_o;
  logic [1:0]  fill_way_o;
  logic [31:0] fill_addr_o;
  logic [3:0]  fill_word_o;
  logic [31:0] fill_data_o;
  logic        tag_we_o;
  logic        tag_valid_o;
  logic        refill_done_o;
  logic        refill_err_o;
  logic        busy_o;

  icache_refill_ctrl dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .miss_valid_i(miss_valid_i), .miss_ready_o(miss_ready_o),
    .miss_addr_i(miss_addr_i), .miss_way_i(miss_way_i), .flush_i(flush_i),
    .mem_req_valid_o(mem_req_valid_o), .mem_req_ready_i(mem_req_ready_i),
    .mem_req_addr_o(mem_req_addr_o), .mem_req_len_o(mem_req_len_o),
    .mem_rvalid_i(mem_rvalid_i), .mem_rready_o(mem_rready_o),
    .mem_rdata_i(mem_rdata_i), .mem_rlast_i(mem_rlast_i), .mem_rerr_i(mem_rerr_i),
    .fill_we_o(fill_we_o), .fill_way_o(fill_way_o), .fill_addr_o(fill_addr_o),
    .fill_word_o(fill_word_o), .fill_data_o(fill_data_o),
    .tag_we_o(tag_we_o), .tag_valid_o(tag_valid_o),
    .refill_done_o(refill_done_o), .refill_err_o(refill_err_o), .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  logic outs_nz;
  assign outs_nz = busy_o | mem_req_valid_o | (|mem_req_addr_o) | (|mem_req_len_o) |
                   mem_rready_o | fill_we_o | (|fill_way_o) | (|fill_addr_o) |
                   (|fill_word_o) | (|fill_data_o) | tag_we_o | tag_valid_o |
                   refill_done_o | refill_err_o;

  typedef struct packed {
    logic [3:0]  word;
    logic [31:0] data;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   failures = 0;

  int          r_writes, r_beats, r_done, r_err, r_tag_we, r_latency, r_req_hs;
  bit          r_tag_valid, r_unstable, r_rst_idle_ok, r_ready_commit;
  logic [31:0] r_req_addr;
  logic [7:0]  r_req_len;

  task automatic idle_inputs();
    miss_valid_i = 1'b0; miss_addr_i = '0; miss_way_i = '0; flush_i = 1'b0;
    mem_req_ready_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = '0;
    mem_rlast_i = 1'b0; mem_rerr_i = 1'b0;
  endtask

  // One complete miss; beat-level errors/flush/reset are injected at the given beat index.
  task automatic do_refill(input logic [31:0] addr, input logic [1:0] way,
                           input logic [31:0] dbase, input bit stall,
                           input int flush_beat, input int rerr_beat,
                           input int rlast_beat, input int rst_beat,
                           input bit flush_commit);
    int   cyc, b, wait_n;
    bit   pend, fin, err_m, abort_m, acc;
    exp_t e;
    logic [31:0] line;
    line = addr & ~32'h3F;
    r_writes = 0; r_beats = 0; r_done = 0; r_err = 0; r_tag_we = 0; r_latency = -1;
    r_req_hs = 0; r_tag_valid = 1'b0; r_unstable = 1'b0; r_rst_idle_ok = 1'b0;
    r_ready_commit = 1'b0; r_req_addr = '0; r_req_len = '0;
    pend = 0; fin = 0; err_m = 0; abort_m = 0; b = 0; cyc = 0; wait_n = 0;
    q.delete();

    @(posedge clk_i); #1;
    miss_valid_i = 1'b1; miss_addr_i = addr; miss_way_i = way;
    @(negedge clk_i);
    while (!miss_ready_o && wait_n < 50) begin
      @(posedge clk_i); #1; @(negedge clk_i); wait_n++;
    end
    if (!miss_ready_o) begin
      checks++; failures++;
      $display("FAIL miss_accept: miss_ready_o stayed %0b, required 1", miss_ready_o);
      miss_valid_i = 1'b0;
      return;
    end

    while (!fin && cyc < 400) begin
      @(posedge clk_i); #1; cyc++;
      miss_valid_i = 1'b0; flush_i = 1'b0; rst_i = 1'b0;
      mem_req_ready_i = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      mem_rvalid_i    = (b < 16) ? (stall ? 1'($urandom_range(0, 1)) : 1'b1) : 1'b0;
      mem_rdata_i     = dbase + 32'(b);
      mem_rlast_i     = (b == 15) ^ (b == rlast_beat);
      mem_rerr_i      = (b == rerr_beat);
      acc = mem_rvalid_i && mem_rready_o;
      if (acc && b == flush_beat) flush_i = 1'b1;
      if (acc && b == rst_beat) rst_i = 1'b1;
      if (flush_commit && tag_we_o) flush_i = 1'b1;
      @(negedge clk_i);

      if (mem_req_valid_o) begin
        if (pend && (mem_req_addr_o !== r_req_addr || mem_req_len_o !== r_req_len))
          r_unstable = 1'b1;
        pend = 1; r_req_addr = mem_req_addr_o; r_req_len = mem_req_len_o;
        if (mem_req_ready_i) begin pend = 0; r_req_hs++; end
      end
      if (acc) begin
        abort_m |= flush_i;
        if (!abort_m && !err_m && !mem_rerr_i) begin
          e.word = b[3:0]; e.data = mem_rdata_i; q.push_back(e);
        end
        err_m |= mem_rerr_i | (mem_rlast_i != (b == 15));
        b++; r_beats++;
      end
      if (fill_we_o) begin
        r_writes++;
        checks++;
        if (q.size() == 0) begin
          failures++;
          $display("FAIL fill_extra: write word=%0d data=%h, required none", fill_word_o, fill_data_o);
        end else begin
          e = q.pop_front();
          if ({fill_word_o, fill_data_o, fill_way_o, fill_addr_o} !== {e.word, e.data, way, line}) begin
            failures++;
            $display("FAIL fill_write: word=%0d data=%h way=%0d addr=%h, required word=%0d data=%h way=%0d addr=%h",
                     fill_word_o, fill_data_o, fill_way_o, fill_addr_o, e.word, e.data, way, line);
          end
        end
      end
      if (refill_done_o) begin r_done++; r_latency = cyc; end
      if (refill_err_o) r_err++;
      if (rst_i) begin
        @(posedge clk_i); #1;
        idle_inputs(); rst_i = 1'b0;
        @(negedge clk_i);
        r_rst_idle_ok = miss_ready_o && !outs_nz;
        fin = 1;
      end
      if (tag_we_o) begin
        r_tag_we++; r_tag_valid = tag_valid_o; r_ready_commit = miss_ready_o; fin = 1;
      end
    end
    checks++;
    if (!fin) begin
      failures++;
      $display("FAIL refill_timeout: no completion after %0d cycles, required within 400", cyc);
    end
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL fill_missing: %0d expected writes never seen, required 0", q.size());
    end
    idle_inputs();
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_i = 1'b1;
    repeat (3) @(posedge clk_i);
    #1 rst_i = 1'b0;
    @(negedge clk_i);
    checks++;
    if ({miss_ready_o, outs_nz} !== 2'b10) begin
      failures++;
      $display("FAIL reset_state: miss_ready=%0b other_outs_nonzero=%0b, required 1 and 0", miss_ready_o, outs_nz);
    end
  endtask

  task automatic test_flush_idle();
    @(posedge clk_i); #1;
    flush_i = 1'b1; miss_valid_i = 1'b1; miss_addr_i = 32'h40; miss_way_i = 2'd1;
    @(negedge clk_i);
    checks++;
    if (miss_ready_o !== 1'b0) begin
      failures++;
      $display("FAIL flush_idle_ready: miss_ready=%0b, required 0", miss_ready_o);
    end
    @(posedge clk_i); #1; idle_inputs();
    @(negedge clk_i);
    checks++;
    if ({busy_o, miss_ready_o} !== 2'b01) begin
      failures++;
      $display("FAIL flush_idle_accept: busy=%0b ready=%0b, required 0 and 1", busy_o, miss_ready_o);
    end
  endtask

  task automatic test_basic();
    do_refill(32'h0000_1234, 2'd2, 32'd0, 0, -1, -1, -1, -1, 0);
    checks++;
    if ({r_req_addr, r_req_len} !== {32'h0000_1200, 8'd15}) begin
      failures++;
      $display("FAIL basic_req: addr=%h len=%0d, required 00001200 15", r_req_addr, r_req_len);
    end
    checks++;
    if (r_writes != 16 || r_beats != 16) begin
      failures++;
      $display("FAIL basic_writes: writes=%0d beats=%0d, required 16 16", r_writes, r_beats);
    end
    checks++;
    if (r_tag_we != 1 || r_tag_valid !== 1'b1 || r_done != 1 || r_err != 0) begin
      failures++;
      $display("FAIL basic_commit: tag_we=%0d valid=%0b done=%0d err=%0d, required 1 1 1 0",
               r_tag_we, r_tag_valid, r_done, r_err);
    end
    checks++;
    if (r_latency != 18) begin
      failures++;
      $display("FAIL basic_latency: done at cycle %0d, required 18", r_latency);
    end
    checks++;
    if (r_ready_commit !== 1'b0) begin
      failures++;
      $display("FAIL commit_ready: miss_ready in COMMIT=%0b, required 0", r_ready_commit);
    end
  endtask

  task automatic test_stall();
    for (int i = 0; i < 3; i++) begin
      do_refill(32'h8000_0000 + 32'(i * 32'h1C4), 2'(i), 32'hA500_0000 + 32'(i << 8), 1, -1, -1, -1, -1, 0);
      checks++;
      if (r_unstable || r_req_hs != 1 || r_writes != 16 || r_done != 1 || r_err != 0) begin
        failures++;
        $display("FAIL stall_%0d: unstable=%0b hs=%0d writes=%0d done=%0d err=%0d, required 0 1 16 1 0",
                 i, r_unstable, r_req_hs, r_writes, r_done, r_err);
      end
    end
  endtask

  task automatic test_flush_recv();
    do_refill(32'h0000_2040, 2'd1, 32'h100, 0, 5, -1, -1, -1, 0);
    checks++;
    if (r_writes != 5 || r_beats != 16 || r_tag_we != 1 || r_tag_valid !== 1'b0 || r_done != 1 || r_err != 0) begin
      failures++;
      $display("FAIL flush_recv: writes=%0d beats=%0d tag_we=%0d valid=%0b done=%0d err=%0d, required 5 16 1 0 1 0",
               r_writes, r_beats, r_tag_we, r_tag_valid, r_done, r_err);
    end
  endtask

  task automatic test_rerr();
    do_refill(32'h0000_3000, 2'd3, 32'h200, 0, -1, 9, -1, -1, 0);
    checks++;
    if (r_writes != 9 || r_beats != 16 || r_tag_valid !== 1'b0 || r_done != 0 || r_err != 1) begin
      failures++;
      $display("FAIL rerr: writes=%0d beats=%0d valid=%0b done=%0d err=%0d, required 9 16 0 0 1",
               r_writes, r_beats, r_tag_valid, r_done, r_err);
    end
  endtask

  task automatic test_rlast();
    do_refill(32'h0000_4000, 2'd0, 32'h300, 0, -1, -1, 7, -1, 0);
    checks++;
    if (r_beats != 16 || r_writes != 8 || r_done != 0 || r_err != 1 || r_tag_valid !== 1'b0) begin
      failures++;
      $display("FAIL rlast: beats=%0d writes=%0d done=%0d err=%0d valid=%0b, required 16 8 0 1 0",
               r_beats, r_writes, r_done, r_err, r_tag_valid);
    end
  endtask

  task automatic test_flush_commit();
    do_refill(32'h0000_5080, 2'd2, 32'h400, 0, -1, -1, -1, -1, 1);
    checks++;
    if (r_writes != 16 || r_tag_we != 1 || r_tag_valid !== 1'b0 || r_done != 1) begin
      failures++;
      $display("FAIL flush_commit: writes=%0d tag_we=%0d valid=%0b done=%0d, required 16 1 0 1",
               r_writes, r_tag_we, r_tag_valid, r_done);
    end
  endtask

  task automatic test_reset_mid();
    do_refill(32'h0000_6000, 2'd1, 32'h500, 0, -1, -1, -1, 3, 0);
    checks++;
    if (!r_rst_idle_ok || r_tag_we != 0 || r_done != 0 || r_err != 0 || r_writes != 4) begin
      failures++;
      $display("FAIL reset_mid: idle_ok=%0b tag_we=%0d done=%0d err=%0d writes=%0d, required 1 0 0 0 4",
               r_rst_idle_ok, r_tag_we, r_done, r_err, r_writes);
    end
    do_refill(32'h0000_6100, 2'd3, 32'h600, 0, -1, -1, -1, -1, 0);
    checks++;
    if (r_writes != 16 || r_done != 1 || r_tag_valid !== 1'b1 || r_latency != 18) begin
      failures++;
      $display("FAIL reset_recover: writes=%0d done=%0d valid=%0b lat=%0d, required 16 1 1 18",
               r_writes, r_done, r_tag_valid, r_latency);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 2; i++) begin
      do_refill(32'h0001_0000 + 32'(i * 64), 2'(i + 1), 32'h700 + 32'(i * 16), 0, -1, -1, -1, -1, 0);
      checks++;
      if (r_writes != 16 || r_done != 1 || r_latency != 18 || r_req_addr !== 32'h0001_0000 + 32'(i * 64)) begin
        failures++;
        $display("FAIL back_to_back_%0d: writes=%0d done=%0d lat=%0d addr=%h, required 16 1 18 %h",
                 i, r_writes, r_done, r_latency, r_req_addr, 32'h0001_0000 + 32'(i * 64));
      end
    end
  endtask

  initial begin
    test_reset();
    test_flush_idle();
    test_basic();
    test_stall();
    test_flush_recv();
    test_rerr();
    test_rlast();
    test_flush_commit();
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
